fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 126 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pulls words from a fifo_sync read port (1-cycle read latency)
// into a 2-entry skid buffer and presents them as a valid/ready stream.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fifo_empty,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic                  o_fifo_rd,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_ready,
   input  logic                  i_flush,
   output logic [CNT_WIDTH-1:0]  o_count
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e                  occ_r;
   occ_e                  occ_nxt_s;
   logic                  inflight_r;
   logic                  valid_r;
   logic                  valid_nxt_s;
   logic [DATA_WIDTH-1:0] head_r;
   logic [DATA_WIDTH-1:0] head_nxt_s;
   logic [DATA_WIDTH-1:0] tail_r;
   logic [DATA_WIDTH-1:0] tail_nxt_s;
   logic [CNT_WIDTH-1:0]  count_r;
   logic [CNT_WIDTH-1:0]  count_nxt_s;
   logic                  take_s;
   logic                  capture_s;
   logic                  fifo_rd_s;
   logic [2:0]            pending_s;

   assign take_s    = valid_r & i_ready;
   assign capture_s = inflight_r & ~i_flush;

   // Slots committed after this edge; a read is only issued if its word is guaranteed a slot.
   assign pending_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, take_s};
   assign fifo_rd_s = ~i_rst & ~i_fifo_empty & ~i_flush & (pending_s < 3'd2);

   assign o_fifo_rd = fifo_rd_s;
   assign o_valid   = valid_r;
   assign o_data    = head_r;
   assign o_count   = count_r;

   // State register: occupancy, in-flight flag, buffer entries and delivered count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         occ_r      <= OCC_EMPTY;
         inflight_r <= 1'b0;
         valid_r    <= 1'b0;
         head_r     <= {DATA_WIDTH{1'b0}};
         tail_r     <= {DATA_WIDTH{1'b0}};
         count_r    <= {CNT_WIDTH{1'b0}};
      end else begin
         occ_r      <= occ_nxt_s;
         inflight_r <= fifo_rd_s;
         valid_r    <= valid_nxt_s;
         head_r     <= head_nxt_s;
         tail_r     <= tail_nxt_s;
         count_r    <= count_nxt_s;
      end
   end

   // Next-state: head is always the oldest word, tail only used while FULL.
   always_comb begin
      occ_nxt_s  = occ_r;
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      if (i_flush) begin
         occ_nxt_s = OCC_EMPTY;
      end else begin
         case (occ_r)
            OCC_EMPTY: begin
               if (capture_s) begin
                  occ_nxt_s  = OCC_ONE;
                  head_nxt_s = i_fifo_data;
               end else begin
                  occ_nxt_s  = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (capture_s && take_s) begin
                  head_nxt_s = i_fifo_data;
               end else if (capture_s) begin
                  occ_nxt_s  = OCC_FULL;
                  tail_nxt_s = i_fifo_data;
               end else if (take_s) begin
                  occ_nxt_s  = OCC_EMPTY;
               end else begin
                  occ_nxt_s  = OCC_ONE;
               end
            end
            OCC_FULL: begin
               if (take_s) begin
                  head_nxt_s = tail_r;
                  if (capture_s) begin
                     tail_nxt_s = i_fifo_data;
                  end else begin
                     occ_nxt_s  = OCC_ONE;
                  end
               end else begin
                  occ_nxt_s = OCC_FULL;
               end
            end
            default: begin
               occ_nxt_s = OCC_EMPTY;
            end
         endcase
      end
      valid_nxt_s = (occ_nxt_s != OCC_EMPTY);
      if (take_s) begin
         count_nxt_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_nxt_s = count_r;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: an upstream FIFO model with 1-cycle read
// latency feeds the DUT; expected stream values are hand-computed per cycle.
module tb_fifo_rd_stream;

   localparam int DW = 16;
   localparam int CW = 4;

   logic          clk_s = 1'b0;
   logic          rst_s;
   logic          fifo_empty_s;
   logic [DW-1:0] fifo_data_r = 16'h0000;
   logic          fifo_rd_s;
   logic          valid_s;
   logic [DW-1:0] data_s;
   logic          ready_s;
   logic          flush_s;
   logic [CW-1:0] count_s;

   logic [DW-1:0] mem [0:63];
   int            n_words = 0;
   int            rd_ptr  = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            exp_idx;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk       (clk_s),
      .i_rst       (rst_s),
      .i_fifo_empty(fifo_empty_s),
      .i_fifo_data (fifo_data_r),
      .o_fifo_rd   (fifo_rd_s),
      .o_valid     (valid_s),
      .o_data      (data_s),
      .i_ready     (ready_s),
      .i_flush     (flush_s),
      .o_count     (count_s)
   );

   always #5 clk_s = ~clk_s;

   assign fifo_empty_s = (rd_ptr >= n_words);

   // Upstream FIFO model: data appears the cycle after the read strobe.
   always @(posedge clk_s) begin
      if (fifo_rd_s && rd_ptr < 64) begin
         fifo_data_r <= mem[rd_ptr];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_s);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_s   = 1'b1;
      ready_s = 1'b0;
      flush_s = 1'b0;
      mem[0] = 16'h0A0A; mem[1] = 16'h0B0B; mem[2] = 16'h0C0C;
      for (int i = 0; i < 5; i++) mem[3 + i] = 16'h0010 + 16'(i);
      mem[8] = 16'h0020; mem[9] = 16'h0021;
      for (int i = 0; i < 6; i++) mem[10 + i] = 16'h0030 + 16'(i);
      for (int i = 0; i < 17; i++) mem[16 + i] = 16'h0040 + 16'(i);
      n_words = 3;
      step();
      step();
      check_val("rst_valid", valid_s, 0);
      check_val("rst_data", data_s, 0);
      check_val("rst_count", count_s, 0);
      check_val("rst_rd", fifo_rd_s, 0);

      // A,B,C streamed with ready high
      rst_s   = 1'b0;
      ready_s = 1'b1;
      #1;
      check_val("s1_rd0", fifo_rd_s, 1);
      check_val("s1_valid0", valid_s, 0);
      step();
      check_val("s1_rd1", fifo_rd_s, 1);
      check_val("s1_valid1", valid_s, 0);
      step();
      check_val("s1_valid2", valid_s, 1);
      check_val("s1_dataA", data_s, 16'h0A0A);
      check_val("s1_rd2", fifo_rd_s, 1);
      step();
      check_val("s1_dataB", data_s, 16'h0B0B);
      check_val("s1_rd3", fifo_rd_s, 0);
      step();
      check_val("s1_dataC", data_s, 16'h0C0C);
      step();
      check_val("s1_valid_end", valid_s, 0);
      check_val("s1_count", count_s, 3);

      // Five words with ready low: exactly two reads, head held
      ready_s = 1'b0;
      n_words = 8;
      #1;
      check_val("s2_rd0", fifo_rd_s, 1);
      step();
      check_val("s2_rd1", fifo_rd_s, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("s2_hold_valid", valid_s, 1);
         check_val("s2_hold_data", data_s, 16'h0010);
         check_val("s2_hold_rd", fifo_rd_s, 0);
      end
      check_val("s2_reads", rd_ptr, 5);
      ready_s = 1'b1;
      #1;
      check_val("s2_restart_rd", fifo_rd_s, 1);
      for (int i = 0; i < 5; i++) begin
         check_val("s2_stream_valid", valid_s, 1);
         check_val("s2_stream_data", data_s, 16'h0010 + 16'(i));
         step();
      end
      check_val("s2_valid_end", valid_s, 0);
      check_val("s2_count", count_s, 8);

      // Empty upstream: no reads, no output
      for (int i = 0; i < 4; i++) begin
         check_val("s3_rd", fifo_rd_s, 0);
         check_val("s3_valid", valid_s, 0);
         step();
      end

      // Flush with one buffered word and one in flight
      ready_s = 1'b0;
      n_words = 10;
      #1;
      check_val("s4_rd0", fifo_rd_s, 1);
      step();
      check_val("s4_rd1", fifo_rd_s, 1);
      step();
      check_val("s4_valid", valid_s, 1);
      check_val("s4_data", data_s, 16'h0020);
      flush_s = 1'b1;
      #1;
      check_val("s4_flush_rd", fifo_rd_s, 0);
      step();
      flush_s = 1'b0;
      check_val("s4_flushed_valid", valid_s, 0);
      check_val("s4_flushed_count", count_s, 8);
      ready_s = 1'b1;
      step();
      step();
      check_val("s4_drop_valid", valid_s, 0);
      check_val("s4_drop_count", count_s, 8);

      // Asynchronous reset in the middle of streaming
      n_words = 16;
      step();
      step();
      check_val("s5_data0", data_s, 16'h0030);
      step();
      check_val("s5_data1", data_s, 16'h0031);
      check_val("s5_count9", count_s, 9);
      #3;
      rst_s = 1'b1;
      #1;
      check_val("s5_async_valid", valid_s, 0);
      check_val("s5_async_data", data_s, 0);
      check_val("s5_async_count", count_s, 0);
      check_val("s5_async_rd", fifo_rd_s, 0);
      step();
      check_val("s5_hold_valid", valid_s, 0);
      check_val("s5_hold_rd", fifo_rd_s, 0);
      #3;
      rst_s = 1'b0;
      #1;
      check_val("s5_rel_count", count_s, 0);
      check_val("s5_rel_rd", fifo_rd_s, 1);
      step();
      check_val("s5_lat_valid", valid_s, 0);
      step();
      check_val("s5_data3", data_s, 16'h0033);
      step();
      check_val("s5_data4", data_s, 16'h0034);
      step();
      check_val("s5_data5", data_s, 16'h0035);
      step();
      check_val("s5_valid_end", valid_s, 0);
      check_val("s5_count", count_s, 3);

      // Seventeen deliveries wrap the 4-bit counter to 1
      rst_s = 1'b1;
      step();
      rst_s = 1'b0;
      n_words = 33;
      exp_idx = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (valid_s) begin
            check_val("s6_order", data_s, 16'h0040 + 16'(exp_idx));
            exp_idx++;
         end
         step();
      end
      check_val("s6_delivered", exp_idx, 17);
      check_val("s6_count_wrap", count_s, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
